// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered carry,
// so wide operands never build a full-width combinational carry chain.
//
// state | meaning
// IDLE  | Ready=1, waiting for Start; result outputs hold the last completed value
// RUN   | one chunk per edge, least significant chunk first; cnt counts chunks left
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Ready,
  output logic             Busy,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   slice;
  logic             msb_cin;

  // Operands shift right so the active chunk always sits in the low bits.
  assign slice = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_r};

  // On the last chunk the low operand bits are the word MSBs; recover the carry into the MSB.
  assign msb_cin = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ slice[CHUNK-1];

  generate
    if (N == 1) begin : g_single
      assign acc_next = slice[CHUNK-1:0];
    end else begin : g_multi
      assign acc_next = {slice[CHUNK-1:0], acc[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Ready    <= 1'b1;
      Busy     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry_r  <= 1'b0;
      cnt      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh    <= A;
            b_sh    <= Sub ? ~B : B;
            carry_r <= Cin ^ Sub;
            cnt     <= CW'(N - 1);
            Ready   <= 1'b0;
            Busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          acc     <= acc_next;
          carry_r <= slice[CHUNK];
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            Sum      <= acc_next;
            Carry    <= slice[CHUNK];
            Overflow <= msb_cin ^ slice[CHUNK];
            Done     <= 1'b1;
            Ready    <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: WIDTH=16 with CHUNK=4 and CHUNK=16 instances.
module tb_chunked_serial_adder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, start16;
  logic [15:0] A, B;
  logic        Cin, Sub;
  logic        Ready, Busy, Carry, Overflow, Done;
  logic [15:0] Sum;
  logic        ready16, busy16, carry16, ovf16, done16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Ready(Ready), .Busy(Busy), .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .Done(Done)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start16), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Ready(ready16), .Busy(busy16), .Sum(sum16), .Carry(carry16), .Overflow(ovf16), .Done(done16)
  );

  // Advances edge by edge (sampling #1 after each) until Done or the limit expires.
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge Clk); #1;
      cycles++;
    end while (!Done && cycles < limit);
    if (!Done) cycles = -1;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Ready, Busy, Sum, Carry, Overflow, Done} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got R%b B%b S%h C%b V%b D%b, want R1 B0 S0000 C0 V0 D0",
               Ready, Busy, Sum, Carry, Overflow, Done);
    end
    checks++;
    if ({ready16, busy16, sum16, carry16, ovf16, done16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state16: got R%b B%b S%h C%b V%b D%b, want R1 B0 S0000 C0 V0 D0",
               ready16, busy16, sum16, carry16, ovf16, done16);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [15:0] va[7] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
    logic [15:0] vb[7] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
    logic        vc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es[7] = '{16'h5555, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFD};
    logic        ec[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ev[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      accept(va[i], vb[i], vc[i], vs[i]);
      wait_done(12, cyc);
      checks++;
      if (cyc !== 4) begin
        errors++;
        $display("FAIL arith%0d_latency: got %0d cycles, want 4", i, cyc);
      end
      checks++;
      if (Sum !== es[i]) begin
        errors++;
        $display("FAIL arith%0d_sum: got %h, want %h", i, Sum, es[i]);
      end
      checks++;
      if (Carry !== ec[i]) begin
        errors++;
        $display("FAIL arith%0d_carry: got %b, want %b", i, Carry, ec[i]);
      end
      checks++;
      if (Overflow !== ev[i]) begin
        errors++;
        $display("FAIL arith%0d_ovf: got %b, want %b", i, Overflow, ev[i]);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    int extra_done = 0;
    accept(16'h1111, 16'h2222, 1'b0, 1'b0);
    checks++;
    if ({Busy, Ready} !== 2'b10) begin
      errors++;
      $display("FAIL busy_flags: got Busy%b Ready%b, want Busy1 Ready0", Busy, Ready);
    end
    @(posedge Clk); #1;
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b1; Sub = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(12, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL busy_latency: got %0d cycles after ignored start, want 2", cyc);
    end
    checks++;
    if (Sum !== 16'h3333) begin
      errors++;
      $display("FAIL busy_sum: got %h, want 3333", Sum);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (Done || Busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++;
      $display("FAIL busy_not_queued: got %0d busy/done cycles, want 0", extra_done);
    end
  endtask

  task automatic test_midrun_change;
    int cyc;
    accept(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    A = 16'hAAAA; B = 16'hBBBB; Cin = 1'b0; Sub = 1'b1;
    wait_done(12, cyc);
    checks++;
    if ({Sum, Carry, Overflow} !== {16'h1011, 1'b0, 1'b0} || cyc !== 4) begin
      errors++;
      $display("FAIL midrun_change: got S%h C%b V%b after %0d, want S1011 C0 V0 after 4",
               Sum, Carry, Overflow, cyc);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    accept(16'h0100, 16'h0023, 1'b0, 1'b0);
    wait_done(12, cyc);
    checks++;
    if (Sum !== 16'h0123 || Ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got S%h Ready%b, want S0123 Ready1", Sum, Ready);
    end
    accept(16'h8000, 16'h8000, 1'b0, 1'b0);
    checks++;
    if ({Busy, Done, Sum} !== {1'b1, 1'b0, 16'h0123}) begin
      errors++;
      $display("FAIL b2b_accept: got Busy%b Done%b S%h, want Busy1 Done0 S0123", Busy, Done, Sum);
    end
    wait_done(12, cyc);
    checks++;
    if ({Sum, Carry, Overflow} !== {16'h0000, 1'b1, 1'b1} || cyc !== 4) begin
      errors++;
      $display("FAIL b2b_second: got S%h C%b V%b after %0d, want S0000 C1 V1 after 4",
               Sum, Carry, Overflow, cyc);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_midrun;
    int stray = 0;
    accept(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    checks++;
    if ({Ready, Busy, Sum, Carry, Overflow, Done} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midrun: got R%b B%b S%h C%b V%b D%b, want R1 B0 S0000 C0 V0 D0",
               Ready, Busy, Sum, Carry, Overflow, Done);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (Done) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d Done pulses, want 0", stray);
    end
  endtask

  task automatic test_chunk16;
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; Sub = 1'b0; start16 = 1'b1;
    @(posedge Clk); #1;
    start16 = 1'b0;
    checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b1) begin
      errors++;
      $display("FAIL c16_accept: got Done%b Busy%b, want Done0 Busy1", done16, busy16);
    end
    @(posedge Clk); #1;
    checks++;
    if ({done16, ready16, sum16, carry16, ovf16} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL c16_result: got D%b R%b S%h C%b V%b, want D1 R1 S0000 C1 V0",
               done16, ready16, sum16, carry16, ovf16);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; start16 = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    test_reset();
    test_arith();
    test_busy_ignore();
    test_midrun_change();
    test_back_to_back();
    test_reset_midrun();
    test_chunk16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
